// File: rtl/ika9958_slot_pla_if.sv
// ika9958_slot_pla_if
// Bundles the run-time configuration inputs and the registered timing outputs
// of the horizontal slot counter / window decoder.
//   master : timing controller side (drives enable, period, wrap, sync, windows;
//            observes counter, phase decode, strobes and windows)
//   slave  : ika9958_slot_pla side
// Widths: CW = TILE_W+PIX_W counter bits, PH_W = 2**PIX_W phase lines.
interface ika9958_slot_pla_if #(
  parameter int unsigned TILE_W  = 5,
  parameter int unsigned PIX_W   = 4,
  parameter int unsigned NUM_WIN = 8
);
  localparam int unsigned CW   = TILE_W + PIX_W;
  localparam int unsigned PH_W = 1 << PIX_W;

  // configuration / control towards the slot counter
  logic                   phiA_cen;
  logic [PIX_W-1:0]       pix_period;
  logic [CW-1:0]          hwrap_val;
  logic                   hsync_ld;
  logic [NUM_WIN*CW-1:0]  win_set;
  logic [NUM_WIN*CW-1:0]  win_rst;
  logic [NUM_WIN-1:0]     win_en;

  // registered timing outputs
  logic [CW-1:0]          cpc;
  logic [PIX_W-1:0]       cpc_z;
  logic [PH_W-1:0]        phase_oh;
  logic                   eot;
  logic                   eol;
  logic [NUM_WIN-1:0]     win;

  modport master (
    output phiA_cen, pix_period, hwrap_val, hsync_ld, win_set, win_rst, win_en,
    input  cpc, cpc_z, phase_oh, eot, eol, win
  );

  modport slave (
    input  phiA_cen, pix_period, hwrap_val, hsync_ld, win_set, win_rst, win_en,
    output cpc, cpc_z, phase_oh, eot, eol, win
  );
endinterface

// File: rtl/ika9958_slot_pla.sv
// ika9958_slot_pla
// Horizontal slot counter and window decoder. The counter is split into a
// tile field (upper TILE_W bits) and a pixel-cycle field (lower PIX_W bits);
// the number of pixel cycles per tile is programmable at run time. Produces
// end-of-tile / end-of-line strobes, a one-cycle-late phase decode and
// NUM_WIN programmable set/reset windows. Every output is a flop.
// Ports:
//   phiA : master clock, all state changes on its rising edge
//   RST  : synchronous active-high reset (overrides the advance enable)
//   bus  : slave side of ika9958_slot_pla_if (config in, timing out)
module ika9958_slot_pla #(
  parameter int unsigned                  TILE_W   = 5,
  parameter int unsigned                  PIX_W    = 4,
  parameter int unsigned                  NUM_WIN  = 8,
  parameter logic [TILE_W+PIX_W-1:0]      LOAD_VAL = (TILE_W+PIX_W)'(9'h1EC)
) (
  input logic               phiA,
  input logic               RST,
  ika9958_slot_pla_if.slave bus
);
  localparam int unsigned CW   = TILE_W + PIX_W;
  localparam int unsigned PH_W = 1 << PIX_W;

  logic [CW-1:0]      cpc_q,      cpc_d;
  logic [PIX_W-1:0]   cpc_z_q,    cpc_z_d;
  logic [PH_W-1:0]    phase_oh_q, phase_oh_d;
  logic               eot_q,      eot_d;
  logic               eol_q,      eol_d;
  logic [NUM_WIN-1:0] win_q,      win_d;

  // Field split and compares on the pre-update counter value.
  logic [PIX_W-1:0]  pix_c;
  logic [TILE_W-1:0] tile_c;
  logic              tile_end_c;
  logic              line_end_c;

  assign pix_c      = cpc_q[PIX_W-1:0];
  assign tile_c     = cpc_q[CW-1:PIX_W];
  // >= rather than == so shrinking the period mid-tile ends the tile at once
  assign tile_end_c = (pix_c >= bus.pix_period);
  assign line_end_c = (cpc_q == bus.hwrap_val);

  // Next-state logic; everything holds while phiA_cen is low.
  always_comb begin
    cpc_d      = cpc_q;
    cpc_z_d    = cpc_z_q;
    phase_oh_d = phase_oh_q;
    eot_d      = eot_q;
    eol_d      = eol_q;
    win_d      = win_q;

    if (bus.phiA_cen) begin
      // Counter: resync load > line wrap > tile carry > pixel increment.
      if (bus.hsync_ld) begin
        cpc_d = LOAD_VAL;
      end else if (line_end_c) begin
        cpc_d = '0;
      end else if (tile_end_c) begin
        cpc_d = {TILE_W'(tile_c + TILE_W'(1)), PIX_W'(0)};
      end else begin
        cpc_d = {tile_c, PIX_W'(pix_c + PIX_W'(1))};
      end

      // A resync load suppresses both strobes on its cycle.
      eot_d = tile_end_c & ~bus.hsync_ld;
      eol_d = line_end_c & ~bus.hsync_ld;

      // Phase decode lags the counter by one enabled cycle.
      cpc_z_d    = pix_c;
      phase_oh_d = PH_W'(1) << pix_c;

      // Windows: reset compare dominates set compare; hsync_ld does not clear.
      for (int unsigned i = 0; i < NUM_WIN; i++) begin
        if (!bus.win_en[i]) begin
          win_d[i] = 1'b0;
        end else if (cpc_q == bus.win_rst[i*CW +: CW]) begin
          win_d[i] = 1'b0;
        end else if (cpc_q == bus.win_set[i*CW +: CW]) begin
          win_d[i] = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge phiA) begin
    if (RST) begin
      cpc_q      <= '0;
      cpc_z_q    <= '0;
      phase_oh_q <= PH_W'(1);
      eot_q      <= 1'b0;
      eol_q      <= 1'b0;
      win_q      <= '0;
    end else begin
      cpc_q      <= cpc_d;
      cpc_z_q    <= cpc_z_d;
      phase_oh_q <= phase_oh_d;
      eot_q      <= eot_d;
      eol_q      <= eol_d;
      win_q      <= win_d;
    end
  end

  assign bus.cpc      = cpc_q;
  assign bus.cpc_z    = cpc_z_q;
  assign bus.phase_oh = phase_oh_q;
  assign bus.eot      = eot_q;
  assign bus.eol      = eol_q;
  assign bus.win      = win_q;
endmodule

// File: doc/ika9958_slot_pla.md
Name: ika9958_slot_pla

Overview:
- Parametrised successor of the common-PLA horizontal slot counter and window decoder.
- Counter layout: a tile field (upper bits) and a pixel-cycle field (lower bits).
- Pixel cycles per tile are set at run time (12 for text, 16 for graphics, or any other value up to 2^PIX_W).
- Generates end-of-tile and end-of-line strobes, registered phase decodes, and NUM_WIN run-time-programmable set/reset timing windows.
- Sits between the reset/clock control and the memory/render PLAs; consumers read only registered outputs.

Parameters:
- TILE_W, 5, width of the tile field.
- PIX_W, 4, width of the pixel-cycle field.
- NUM_WIN, 8, number of programmable set/reset windows.
- LOAD_VAL, 9'h1EC, counter value loaded on hsync_ld. Width is TILE_W+PIX_W.

Ports:
(CW = TILE_W+PIX_W)
- phiA, in, 1, master clock; all state changes on its posedge.
- RST, in, 1, synchronous active-high reset.
- phiA_cen, in, 1, advance enable; when 0 all state holds.
- pix_period, in, PIX_W, last pixel cycle index of a tile (11 = text, 15 = graphics).
- hwrap_val, in, CW, last counter value of a line.
- hsync_ld, in, 1, line-resync request; loads LOAD_VAL.
- win_set, in, NUM_WIN*CW, per-window set compare values, packed LSB = window 0.
- win_rst, in, NUM_WIN*CW, per-window reset compare values.
- win_en, in, NUM_WIN, per-window enable.
- cpc, out, CW, current counter value.
- cpc_z, out, PIX_W, pixel field registered one enabled cycle late.
- phase_oh, out, 2**PIX_W, one-hot of cpc_z.
- eot, out, 1, end-of-tile strobe.
- eol, out, 1, end-of-line strobe.
- win, out, NUM_WIN, window states.

Behaviour:
- All outputs are registered. Nothing changes unless phiA_cen=1 at a phiA posedge, except RST, which acts regardless of phiA_cen.
- Reset values:
  - cpc = 0, cpc_z = 0, phase_oh = 1 (bit 0 set).
  - eot = 0, eol = 0, win = 0.
- Counter update per enabled cycle. Priority is RST > hsync_ld > line wrap > tile carry > increment. Let pix = cpc[PIX_W-1:0] and tile = cpc[CW-1:PIX_W].
  1. hsync_ld=1: cpc <= LOAD_VAL.
  2. Else if cpc == hwrap_val: cpc <= 0.
  3. Else if pix >= pix_period: pix <= 0 and tile <= tile+1, modulo 2^TILE_W. The `>=` compare makes a mid-tile period shrink end the tile immediately; no overrun.
  4. Else pix <= pix+1.
- Strobes, each high for one enabled cycle, computed from pre-update cpc:
  - eot <= pix >= pix_period and not hsync_ld. A line wrap landing on the last pixel also pulses eot.
  - eol <= cpc == hwrap_val and not hsync_ld.
- cpc_z <= pix; phase_oh <= one-hot(pix). These lag cpc by exactly one enabled cycle.
- Windows, per i, all compares against pre-update cpc:
  - win_en[i]=0: win[i] <= 0.
  - Else if cpc == win_rst[i]: win[i] <= 0. Reset wins when set and reset match simultaneously.
  - Else if cpc == win_set[i]: win[i] <= 1.
  - Else win[i] holds.
  - Latency: win[i] rises on the edge that leaves the set value; it is visible while cpc equals set+1.
  - Windows spanning a wrap (set > rst) are legal and stay asserted across the wrap.
  - Windows are not cleared by hsync_ld.
- Run-time input changes: pix_period, hwrap_val and window registers may change at any time and take effect on the next enabled cycle. No shadowing.
- hwrap_val >= 2^CW cannot occur by width. If hwrap_val is never reached, the counter free-runs modulo 2^CW.
- RST asserted mid-line returns to reset values on the next edge. The first enabled cycle after deassert counts from 0.

Test Plan:
1. RST, then pix_period=15, hwrap_val=9'h155, cen=1 for 400 cycles.
   - Required: cpc steps 0..15 then 16; eot pulses every 16 cycles.
   - Required: after cpc = 9'h155, cpc = 0 and eol pulses once.
2. pix_period=11.
   - Required: pix goes 0..11 then 0; tile increments every 12 cycles; phase_oh[11] is the highest bit seen.
   - Then switch to 15 when pix=5: required 16-cycle tiles resume without glitch.
3. hsync_ld pulse at cpc=9'h037.
   - Required: next cpc = 9'h1EC and no eot/eol on that cycle.
   - hsync_ld and line wrap in the same cycle: required cpc = LOAD_VAL.
4. Window 0 with set=9'h010, rst=9'h014, en=1.
   - Required: win[0]=1 exactly while cpc in 9'h011..9'h014, i.e. 4 cycles.
   - Window 1 with set=rst=9'h020: required win[1] never asserts.
5. phiA_cen toggled 1,0,0,1.
   - Required: cpc, cpc_z and all strobes hold during the 0 cycles; a held eot stays high and is not re-pulsed.
6. RST asserted at cpc=9'h0A7 with win[0]=1.
   - Required: all outputs return to reset values on the next edge; counting restarts at 0.
